// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon AEAD control sequencer: FSM states,
// phase classification and the default block size.
package ascon_pkg;

  localparam int unsigned ASCON_BLK_BYTES = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_AD_WAIT,
    S_AD_RUN,
    S_TXT_WAIT,
    S_TXT_RUN,
    S_TXT_OUT,
    S_FINAL,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_NONE,
    PH_AD,
    PH_TXT
  } phase_t;

  function automatic phase_t phase_of(input state_t s);
    case (s)
      S_AD_WAIT, S_AD_RUN:               return PH_AD;
      S_TXT_WAIT, S_TXT_RUN, S_TXT_OUT:  return PH_TXT;
      default:                           return PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ascon_blk_counter.sv
// Block index / data_position generator, 2-cycle run counter and
// last-block detection for the Ascon sequencer.
module ascon_blk_counter
  import ascon_pkg::*;
#(
  parameter int unsigned BLK_BYTES = ASCON_BLK_BYTES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_inc,
  input  logic        i_run,
  input  logic [32:0] i_nblk,
  output logic [31:0] o_pos,
  output logic        o_run_last,
  output logic        o_last_blk
);

  logic [31:0] r_idx;
  logic        r_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_inc) begin
      r_idx <= r_idx + 32'd1;
    end
  end

  // Toggles through the two absorb cycles; idles at 0 outside a run state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else if (i_run) begin
      r_run <= ~r_run;
    end else begin
      r_run <= 1'b0;
    end
  end

  assign o_pos      = r_idx * 32'(BLK_BYTES);
  assign o_run_last = r_run;
  assign o_last_blk = ({1'b0, r_idx} + 33'd1) >= i_nblk;

endmodule

// File: rtl/ascon_sequencer.sv
// Ascon AEAD run sequencer: phase FSM, block/tag registers and the
// process_en_* strobe interface towards the core.
module ascon_sequencer
  import ascon_pkg::*;
#(
  parameter int unsigned BLK_BYTES = ASCON_BLK_BYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         decrypt,
  input  logic [31:0]  ad_len,
  input  logic [31:0]  txt_len,
  input  logic [127:0] tag_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic         done,
  output logic [127:0] tag_out,
  output logic         tag_match,
  output logic         err_o,
  output logic         core_en_init,
  output logic         core_en_ad,
  output logic         core_en_txt,
  output logic         core_en_final,
  output logic         core_mode,
  output logic [31:0]  core_len,
  output logic [31:0]  core_pos,
  output logic [127:0] core_din,
  input  logic [127:0] core_dout,
  input  logic [127:0] core_tag,
  input  logic         core_err
);

  state_t       r_state;
  state_t       w_state_nxt;
  phase_t       w_phase;
  logic         r_decrypt;
  logic [31:0]  r_ad_len;
  logic [31:0]  r_txt_len;
  logic [127:0] r_blk;
  logic [127:0] r_out;
  logic [127:0] r_tag;
  logic         r_match;
  logic         r_err;

  logic         w_start;
  logic         w_cnt_clr;
  logic         w_cnt_inc;
  logic         w_run;
  logic         w_blk_ld;
  logic         w_out_ld;
  logic [32:0]  w_ad_nblk;
  logic [32:0]  w_txt_nblk;
  logic [32:0]  w_nblk;
  logic [31:0]  w_pos;
  logic         w_run_last;
  logic         w_last_blk;

  assign w_phase    = phase_of(r_state);
  // 33-bit arithmetic keeps the block counts exact for lengths near 2^32.
  assign w_ad_nblk  = ({1'b0, r_ad_len} + 33'(BLK_BYTES - 1)) / 33'(BLK_BYTES);
  assign w_txt_nblk = ({1'b0, r_txt_len} / 33'(BLK_BYTES)) + 33'd1;
  assign w_nblk     = (w_phase == PH_AD) ? w_ad_nblk : w_txt_nblk;

  ascon_blk_counter #(.BLK_BYTES(BLK_BYTES)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_cnt_clr),
    .i_inc      (w_cnt_inc),
    .i_run      (w_run),
    .i_nblk     (w_nblk),
    .o_pos      (w_pos),
    .o_run_last (w_run_last),
    .o_last_blk (w_last_blk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_run       = 1'b0;
    w_blk_ld    = 1'b0;
    w_out_ld    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start     = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_INIT;
        end
      end
      S_INIT: begin
        w_state_nxt = (r_ad_len == '0) ? S_TXT_WAIT : S_AD_WAIT;
      end
      S_AD_WAIT: begin
        if (in_valid) begin
          w_blk_ld    = 1'b1;
          w_state_nxt = S_AD_RUN;
        end
      end
      S_AD_RUN: begin
        w_run = 1'b1;
        if (w_run_last) begin
          if (w_last_blk) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_TXT_WAIT;
          end else begin
            w_cnt_inc   = 1'b1;
            w_state_nxt = S_AD_WAIT;
          end
        end
      end
      S_TXT_WAIT: begin
        if (in_valid) begin
          w_blk_ld    = 1'b1;
          w_state_nxt = S_TXT_RUN;
        end
      end
      S_TXT_RUN: begin
        w_run = 1'b1;
        if (w_run_last) begin
          w_out_ld    = 1'b1;
          w_state_nxt = S_TXT_OUT;
        end
      end
      S_TXT_OUT: begin
        if (out_ready) begin
          if (w_last_blk) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_FINAL;
          end else begin
            w_cnt_inc   = 1'b1;
            w_state_nxt = S_TXT_WAIT;
          end
        end
      end
      S_FINAL: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_decrypt <= 1'b0;
      r_ad_len  <= '0;
      r_txt_len <= '0;
      r_blk     <= '0;
      r_out     <= '0;
      r_tag     <= '0;
      r_match   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_start) begin
        r_decrypt <= decrypt;
        r_ad_len  <= ad_len;
        r_txt_len <= txt_len;
        r_tag     <= '0;
        r_match   <= 1'b0;
        r_err     <= 1'b0;
      end else if (r_state != S_IDLE) begin
        r_err <= r_err | core_err;
      end
      if (w_blk_ld) begin
        r_blk <= in_data;
      end
      if (w_out_ld) begin
        r_out <= core_dout;
      end
      if (r_state == S_FINAL) begin
        r_tag   <= core_tag;
        r_match <= r_decrypt && (core_tag == tag_in);
      end
    end
  end

  assign in_ready      = (r_state == S_AD_WAIT) || (r_state == S_TXT_WAIT);
  assign out_valid     = (r_state == S_TXT_OUT);
  assign out_data      = r_out;
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign tag_out       = r_tag;
  assign tag_match     = r_match;
  assign err_o         = r_err;
  assign core_en_init  = (r_state == S_INIT);
  assign core_en_ad    = (r_state == S_AD_RUN);
  assign core_en_txt   = (r_state == S_TXT_RUN);
  assign core_en_final = (r_state == S_FINAL);
  assign core_mode     = r_decrypt;
  assign core_len      = (w_phase == PH_AD)  ? r_ad_len  :
                         (w_phase == PH_TXT) ? r_txt_len : '0;
  assign core_pos      = (w_phase == PH_NONE) ? '0 : w_pos;
  assign core_din      = r_blk;

endmodule

// File: tb/tb_ascon_sequencer.sv
// Self-checking bench for ascon_sequencer with a behavioural core stand-in
// and a per-run reference model derived from lengths and accepted blocks.
module tb_ascon_sequencer;

  localparam logic [127:0] DOUT_K = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         decrypt;
  logic [31:0]  ad_len;
  logic [31:0]  txt_len;
  logic [127:0] tag_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic         done;
  logic [127:0] tag_out;
  logic         tag_match;
  logic         err_o;
  logic         core_en_init;
  logic         core_en_ad;
  logic         core_en_txt;
  logic         core_en_final;
  logic         core_mode;
  logic [31:0]  core_len;
  logic [31:0]  core_pos;
  logic [127:0] core_din;
  logic [127:0] core_dout;
  logic [127:0] core_tag;
  logic         core_err;
  logic [127:0] r_tag_mock;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  // Core stand-in: output block is a keyed function of the block and its position.
  assign core_dout = core_din ^ {4{core_pos}} ^ DOUT_K;
  assign core_tag  = r_tag_mock;

  ascon_sequencer #(.BLK_BYTES(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt),
    .ad_len(ad_len), .txt_len(txt_len), .tag_in(tag_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .tag_out(tag_out), .tag_match(tag_match),
    .err_o(err_o), .core_en_init(core_en_init), .core_en_ad(core_en_ad),
    .core_en_txt(core_en_txt), .core_en_final(core_en_final),
    .core_mode(core_mode), .core_len(core_len), .core_pos(core_pos),
    .core_din(core_din), .core_dout(core_dout), .core_tag(core_tag),
    .core_err(core_err)
  );

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_run(input int unsigned adl, input int unsigned txl,
                        input bit dec, input bit flip, input bit rand_valid,
                        input int unsigned stall_beat, input int unsigned stall_len,
                        input bit inj_err, input string nm);
    int unsigned  nad  = (adl + 15) / 16;
    int unsigned  ntxt = txl / 16 + 1;
    logic [127:0] acc_q[$];
    logic [31:0]  adp_q[$];
    logic [31:0]  txp_q[$];
    int unsigned  cyc = 1, beat = 0, stalled = 0, waits = 0;
    int unsigned  n_init = 0, n_final = 0, k = 0;
    bit           fin = 0, err_done = 0, qbad;
    logic [127:0] exp_d;
    logic [31:0]  pv;

    r_tag_mock = rnd128();
    @(negedge clk);
    start    = 1'b1;
    decrypt  = dec;
    ad_len   = adl;
    txt_len  = txl;
    tag_in   = flip ? (r_tag_mock ^ 128'h1) : r_tag_mock;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;

    total++;
    if (core_en_init !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL %s.init: en_init=%0b busy=%0b expected 1 1", nm, core_en_init, busy);
    end
    total++;
    if (err_o !== 1'b0 || tag_out !== '0 || tag_match !== 1'b0 || core_mode !== dec) begin
      bad++; $display("FAIL %s.start_clear: err=%0b tag=%h match=%0b mode=%0b expected 0 0 0 %0b",
                      nm, err_o, tag_out, tag_match, core_mode, dec);
    end

    while (!fin && cyc < 3000) begin
      core_err = 1'b0;
      n_init  += core_en_init;
      n_final += core_en_final;
      total++;
      if ($countones({core_en_init, core_en_ad, core_en_txt, core_en_final}) > 1) begin
        bad++; $display("FAIL %s.onehot: enables=%b expected at most one", nm,
                        {core_en_init, core_en_ad, core_en_txt, core_en_final});
      end
      if (core_en_ad) begin
        adp_q.push_back(core_pos);
        k = core_pos / 16;
        exp_d = (k < acc_q.size()) ? acc_q[k] : ~core_din;
        total++;
        if (core_len !== adl || core_din !== exp_d) begin
          bad++; $display("FAIL %s.ad_blk: len=%0d din=%h expected %0d %h", nm, core_len, core_din, adl, exp_d);
        end
        if (inj_err && !err_done) begin
          core_err = 1'b1;
          err_done = 1;
        end
      end
      if (core_en_txt) begin
        txp_q.push_back(core_pos);
        k = nad + core_pos / 16;
        exp_d = (k < acc_q.size()) ? acc_q[k] : ~core_din;
        total++;
        if (core_len !== txl || core_din !== exp_d) begin
          bad++; $display("FAIL %s.txt_blk: len=%0d din=%h expected %0d %h", nm, core_len, core_din, txl, exp_d);
        end
      end
      if (out_valid) begin
        pv = beat * 16;
        k  = nad + beat;
        exp_d = (k < acc_q.size()) ? (acc_q[k] ^ {4{pv}} ^ DOUT_K) : ~out_data;
        total++;
        if (out_data !== exp_d || in_ready !== 1'b0 || core_en_ad || core_en_txt) begin
          bad++; $display("FAIL %s.out_beat%0d: data=%h in_ready=%0b expected %h 0", nm, beat, out_data, in_ready, exp_d);
        end
        if (beat == stall_beat && stalled < stall_len) begin
          out_ready = 1'b0;
          stalled++;
        end else begin
          out_ready = 1'b1;
          beat++;
        end
      end else begin
        out_ready = $urandom_range(0, 1) != 0;
      end
      in_data  = rnd128();
      in_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (in_ready) begin
        if (in_valid) acc_q.push_back(in_data);
        else          waits++;
      end
      if (done) begin
        fin = 1;
        total++;
        if (cyc !== 1 + 3 * nad + 4 * ntxt + 2 + waits + stalled) begin
          bad++; $display("FAIL %s.done_cycle: got %0d expected %0d", nm, cyc,
                          1 + 3 * nad + 4 * ntxt + 2 + waits + stalled);
        end
        total++;
        if (tag_out !== r_tag_mock || tag_match !== (dec && !flip) || err_o !== inj_err) begin
          bad++; $display("FAIL %s.result: tag=%h match=%0b err=%0b expected %h %0b %0b",
                          nm, tag_out, tag_match, err_o, r_tag_mock, dec && !flip, inj_err);
        end
      end
      @(negedge clk);
      cyc++;
    end

    total++;
    if (!fin) begin
      bad++; $display("FAIL %s.timeout: no done after %0d cycles expected done", nm, cyc);
    end
    total++;
    if (n_init != 1 || n_final != 1 || beat != ntxt) begin
      bad++; $display("FAIL %s.counts: init=%0d final=%0d beats=%0d expected 1 1 %0d", nm, n_init, n_final, beat, ntxt);
    end
    qbad = (adp_q.size() != 2 * nad) || (txp_q.size() != 2 * ntxt);
    for (int unsigned i = 0; i < adp_q.size(); i++) if (adp_q[i] !== (i / 2) * 16) qbad = 1;
    for (int unsigned i = 0; i < txp_q.size(); i++) if (txp_q[i] !== (i / 2) * 16) qbad = 1;
    total++;
    if (qbad) begin
      bad++; $display("FAIL %s.positions: ad_cycles=%0d txt_cycles=%0d expected %0d %0d (pos k*16, 2 cycles each)",
                      nm, adp_q.size(), txp_q.size(), 2 * nad, 2 * ntxt);
    end
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || tag_out !== r_tag_mock || err_o !== inj_err) begin
      bad++; $display("FAIL %s.idle_hold: done=%0b busy=%0b tag=%h err=%0b expected 0 0 %h %0b",
                      nm, done, busy, tag_out, err_o, r_tag_mock, inj_err);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; decrypt = 0; ad_len = '0; txt_len = '0; tag_in = '0;
    in_valid = 0; in_data = '0; out_ready = 0; core_err = 0; r_tag_mock = rnd128();
    #1;
    total++;
    if ({core_en_init, core_en_ad, core_en_txt, core_en_final, in_ready, out_valid, busy, done,
         tag_match, err_o, core_mode, core_len, core_pos, core_din, out_data, tag_out} !== '0) begin
      bad++; $display("FAIL reset: outputs not all zero (busy=%0b in_ready=%0b tag=%h) expected 0", busy, in_ready, tag_out);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_min_run();
    do_run(0, 0, 0, 0, 0, 99, 0, 0, "min_run");
  endtask

  task automatic test_ad_txt();
    do_run(17, 32, 0, 0, 0, 99, 0, 0, "ad17_txt32");
    do_run(16, 16, 0, 0, 0, 99, 0, 0, "ad16_txt16");
  endtask

  task automatic test_decrypt_tag();
    do_run(5, 20, 1, 0, 1, 99, 0, 0, "dec_good");
    do_run(5, 20, 1, 1, 1, 99, 0, 0, "dec_bad");
  endtask

  task automatic test_backpressure();
    do_run(3, 40, 0, 0, 0, 1, 5, 0, "backpressure");
  endtask

  task automatic test_reset_midrun();
    int unsigned n = 0;
    @(negedge clk);
    start = 1'b1; decrypt = 1'b1; ad_len = 0; txt_len = 16; in_valid = 1'b1; in_data = rnd128();
    @(negedge clk);
    start = 1'b0;
    while (!core_en_txt && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!core_en_txt) begin
      bad++; $display("FAIL midrun.reach: core_en_txt=%0b expected 1", core_en_txt);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({core_en_init, core_en_ad, core_en_txt, core_en_final, in_ready, out_valid, busy, done,
         tag_match, err_o, core_mode, core_len, core_pos, core_din, out_data, tag_out} !== '0) begin
      bad++; $display("FAIL midrun.reset: outputs not zero (en_txt=%0b busy=%0b mode=%0b) expected 0",
                      core_en_txt, busy, core_mode);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    do_run(0, 16, 0, 0, 1, 99, 0, 0, "after_reset");
  endtask

  task automatic test_err();
    do_run(20, 3, 0, 0, 0, 99, 0, 1, "err_inject");
    do_run(0, 3, 0, 0, 0, 99, 0, 0, "err_cleared");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      do_run($urandom_range(0, 70), $urandom_range(0, 70), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1, $urandom_range(0, 4), $urandom_range(0, 3), 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_min_run();
    test_ad_txt();
    test_decrypt_tag();
    test_backpressure();
    test_reset_midrun();
    test_err();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
